// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      RESP
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one synchronous write port, one combinational read port.
module icache_data_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache with same-cycle hits, whole-line refill,
// fence.i style invalidate and hit/miss counters.
module i_cache_dm
   import icache_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int LINES  = 64,
   parameter int WORDS  = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_ins,
   input  logic              inv,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int OFF_W  = clog2(WORDS);
   localparam int IDX_W  = clog2(LINES);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int RAM_AW = IDX_W + OFF_W;

   state_t            r_state;
   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag [LINES];
   logic [OFF_W-1:0]  r_beat;
   logic              r_inv_pend;
   logic [IDX_W-1:0]  r_lidx;
   logic [TAG_W-1:0]  r_ltag;
   logic [OFF_W-1:0]  r_loff;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_miss_cnt;

   logic [OFF_W-1:0]  w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic              w_hit;
   logic              w_idle_hit;
   logic              w_idle_miss;
   logic              w_beat;
   logic              w_last;
   logic [RAM_AW-1:0] w_raddr;
   logic [RAM_AW-1:0] w_waddr;
   logic [DATA_W-1:0] w_rdata;

   assign w_off       = cpu_addr[OFF_W-1:0];
   assign w_idx       = cpu_addr[OFF_W +: IDX_W];
   assign w_tag       = cpu_addr[ADDR_W-1 -: TAG_W];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_idle_hit  = (r_state == IDLE) && cpu_req && w_hit;
   assign w_idle_miss = (r_state == IDLE) && cpu_req && !w_hit;
   assign w_beat      = (r_state == REFILL) && mem_rvalid;
   assign w_last      = w_beat && (&r_beat);

   // RESP reads through the latched line so a dropped or changed cpu_addr cannot disturb it.
   assign w_raddr = (r_state == RESP) ? {r_lidx, r_loff} : {w_idx, w_off};
   assign w_waddr = {r_lidx, r_beat};

   assign cpu_ready = w_idle_hit || (r_state == RESP);
   assign cpu_ins   = cpu_ready ? w_rdata : '0;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

   icache_data_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (LINES * WORDS),
      .AW     (RAM_AW)
   ) u_data_ram (
      .clk     (clk),
      .i_we    (w_beat),
      .i_waddr (w_waddr),
      .i_wdata (mem_rdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (w_idle_miss) begin
         r_lidx <= w_idx;
         r_ltag <= w_tag;
         r_loff <= w_off;
      end
      if (w_last) r_tag[r_lidx] <= r_ltag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_valid    <= '0;
         r_beat     <= '0;
         r_inv_pend <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (inv) r_valid <= '0;
               if (w_idle_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
               if (w_idle_miss) begin
                  r_state    <= REFILL;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                  r_beat     <= '0;
                  r_miss_cnt <= r_miss_cnt + 32'd1;
               end
            end
            REFILL: begin
               if (inv) r_inv_pend <= 1'b1;
               if (w_beat) begin
                  r_beat <= r_beat + OFF_W'(1);
                  if (&r_beat) begin
                     r_valid[r_lidx] <= 1'b1;
                     r_mem_req       <= 1'b0;
                     r_state         <= RESP;
                  end
               end
            end
            RESP: begin
               // A deferred invalidate also drops the line that was just filled.
               if (r_inv_pend || inv) r_valid <= '0;
               r_inv_pend <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i_cache_dm.sv
// Bench for i_cache_dm: directed scenarios plus randomized fetches against an address-level cache model.
module tb_i_cache_dm;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int LINES  = 64;
   localparam int WORDS  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cpu_req = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_ins;
   logic              inv = 1'b0;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [31:0]       hit_cnt;
   logic [31:0]       miss_cnt;

   int checks = 0;
   int passed = 0;

   // Backing memory image and the cache model (which line holds which tag).
   logic [31:0] mem_img [int];
   bit          m_valid [LINES];
   int unsigned m_tag   [LINES];
   int unsigned exp_hits = 0;
   int unsigned exp_miss = 0;

   i_cache_dm #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LINES  (LINES),
      .WORDS  (WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_ready  (cpu_ready),
      .cpu_ins    (cpu_ins),
      .inv        (inv),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (mem_img.exists(int'(a))) return mem_img[int'(a)];
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return (a / WORDS) * WORDS;
   endfunction

   function automatic bit m_lookup(input logic [ADDR_W-1:0] a);
      int unsigned ai = a;
      int unsigned idx = (ai / WORDS) % LINES;
      return m_valid[idx] && (m_tag[idx] == ai / (WORDS * LINES));
   endfunction

   task automatic m_clear();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   task automatic m_update(input logic [ADDR_W-1:0] a, input bit hit, input bit inv_idle,
                           input int inv_beat);
      int unsigned ai = a;
      int unsigned idx = (ai / WORDS) % LINES;
      if (inv_idle) m_clear();
      if (hit) exp_hits++;
      else begin
         exp_miss++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = ai / (WORDS * LINES);
         if (inv_beat >= 0) m_clear();
      end
   endtask

   // One fetch with the memory responder; inv_beat in 0..WORDS-1 pulses inv with
   // that beat, inv_beat == WORDS pulses it in the response cycle, -1 never.
   task automatic fetch(input logic [ADDR_W-1:0] a, input int gap, input int inv_beat,
                        input bit inv_idle, output bit hit, output logic [31:0] ins,
                        output logic req_seen, output logic [ADDR_W-1:0] req_addr,
                        output logic resp_ready);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      inv      = inv_idle;
      #1;
      hit        = cpu_ready;
      ins        = cpu_ins;
      req_seen   = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      inv = 1'b0;
      if (hit) begin
         cpu_req = 1'b0;
         return;
      end
      #1;
      req_seen = mem_req;
      req_addr = mem_addr;
      for (int b = 0; b < WORDS; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_word(line_of(a) + ADDR_W'(b));
         inv        = (b == inv_beat);
         @(negedge clk);
         mem_rvalid = 1'b0;
         inv        = 1'b0;
         if (b < WORDS - 1) repeat (gap) @(negedge clk);
      end
      #1;
      resp_ready = cpu_ready;
      ins        = cpu_ins;
      inv        = (inv_beat == WORDS);
      @(negedge clk);
      inv     = 1'b0;
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++; if (cpu_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", cpu_ready); else passed++;
      checks++; if (cpu_ins !== 32'h0) $display("FAIL reset_ins got=%h exp=0", cpu_ins); else passed++;
      checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else passed++;
      checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else passed++;
      checks++; if (hit_cnt !== 32'h0) $display("FAIL reset_hit_cnt got=%h exp=0", hit_cnt); else passed++;
      checks++; if (miss_cnt !== 32'h0) $display("FAIL reset_miss_cnt got=%h exp=0", miss_cnt); else passed++;
      m_clear();
      exp_hits = 0;
      exp_miss = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_cold_miss();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra; logic rr;
      for (int i = 0; i < WORDS; i++) mem_img[4 + i] = 32'hA0 + i;
      fetch(30'h5, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h5, 1'b0, 1'b0, -1);
      checks++; if (h !== 1'b0) $display("FAIL cold_hit got=%b exp=0", h); else passed++;
      checks++; if (rs !== 1'b1) $display("FAIL cold_mem_req got=%b exp=1", rs); else passed++;
      checks++; if (ra !== 30'h4) $display("FAIL cold_mem_addr got=%h exp=4", ra); else passed++;
      checks++; if (rr !== 1'b1) $display("FAIL cold_resp_ready got=%b exp=1", rr); else passed++;
      checks++; if (ins !== 32'hA1) $display("FAIL cold_ins got=%h exp=a1", ins); else passed++;
      #1;
      checks++; if (cpu_ready !== 1'b0) $display("FAIL cold_resp_one_cycle got=%b exp=0", cpu_ready); else passed++;
      checks++; if (miss_cnt !== 32'd1) $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt); else passed++;
   endtask

   task automatic test_hit_after_fill();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra; logic rr;
      fetch(30'h7, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h7, 1'b1, 1'b0, -1);
      checks++; if (h !== 1'b1) $display("FAIL hit_ready got=%b exp=1", h); else passed++;
      checks++; if (ins !== 32'hA3) $display("FAIL hit_ins got=%h exp=a3", ins); else passed++;
      #1;
      checks++; if (mem_req !== 1'b0) $display("FAIL hit_mem_req got=%b exp=0", mem_req); else passed++;
      checks++; if (hit_cnt !== 32'd1) $display("FAIL hit_cnt got=%0d exp=1", hit_cnt); else passed++;
   endtask

   task automatic test_conflict();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra; logic rr;
      fetch(30'h104, 1, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h104, 1'b0, 1'b0, -1);
      checks++; if (h !== 1'b0) $display("FAIL evict_hit got=%b exp=0", h); else passed++;
      checks++; if (ra !== 30'h104) $display("FAIL evict_mem_addr got=%h exp=104", ra); else passed++;
      checks++; if (ins !== mem_word(30'h104)) $display("FAIL evict_ins got=%h exp=%h", ins, mem_word(30'h104)); else passed++;
      checks++; if (miss_cnt !== 32'd2) $display("FAIL evict_miss_cnt got=%0d exp=2", miss_cnt); else passed++;
      fetch(30'h4, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h4, 1'b0, 1'b0, -1);
      checks++; if (h !== 1'b0) $display("FAIL refetch_hit got=%b exp=0", h); else passed++;
      checks++; if (ins !== 32'hA0) $display("FAIL refetch_ins got=%h exp=a0", ins); else passed++;
      checks++; if (miss_cnt !== 32'd3) $display("FAIL refetch_miss_cnt got=%0d exp=3", miss_cnt); else passed++;
   endtask

   task automatic test_stall_inv();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra; logic rr;
      fetch(30'h2A, 3, 1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h2A, 1'b0, 1'b0, 1);
      checks++; if (rr !== 1'b1) $display("FAIL stall_resp_ready got=%b exp=1", rr); else passed++;
      checks++; if (ins !== mem_word(30'h2A)) $display("FAIL stall_ins got=%h exp=%h", ins, mem_word(30'h2A)); else passed++;
      fetch(30'h2A, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(30'h2A, 1'b0, 1'b0, -1);
      checks++; if (h !== 1'b0) $display("FAIL stall_rerequest_hit got=%b exp=0", h); else passed++;
      checks++; if (ins !== mem_word(30'h2A)) $display("FAIL stall_rerequest_ins got=%h exp=%h", ins, mem_word(30'h2A)); else passed++;
   endtask

   task automatic test_random();
      bit h, eh, inv_idle; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra, a; logic rr;
      int gap, inv_beat;
      for (int n = 0; n < 150; n++) begin
         a        = ADDR_W'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
         gap      = $urandom_range(0, 2);
         inv_beat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WORDS) : -1;
         inv_idle = ($urandom_range(0, 15) == 0);
         eh       = m_lookup(a);
         fetch(a, gap, inv_beat, inv_idle, h, ins, rs, ra, rr);
         m_update(a, eh, inv_idle, inv_beat);
         checks++; if (h !== eh) $display("FAIL rnd_hit addr=%h got=%b exp=%b", a, h, eh); else passed++;
         checks++; if (ins !== mem_word(a)) $display("FAIL rnd_ins addr=%h got=%h exp=%h", a, ins, mem_word(a)); else passed++;
         if (!eh) begin
            checks++; if (ra !== line_of(a)) $display("FAIL rnd_mem_addr got=%h exp=%h", ra, line_of(a)); else passed++;
            checks++; if (rr !== 1'b1) $display("FAIL rnd_resp_ready got=%b exp=1", rr); else passed++;
         end
      end
      #1;
      checks++; if (hit_cnt !== exp_hits) $display("FAIL rnd_hit_cnt got=%0d exp=%0d", hit_cnt, exp_hits); else passed++;
      checks++; if (miss_cnt !== exp_miss) $display("FAIL rnd_miss_cnt got=%0d exp=%0d", miss_cnt, exp_miss); else passed++;
   endtask

   task automatic test_reset_mid_refill();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra, a; logic rr;
      a = 30'h3F08;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = a;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hBAD0_0000 + b;
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) $display("FAIL rmid_mem_req got=%b exp=0", mem_req); else passed++;
      checks++; if (miss_cnt !== 32'h0) $display("FAIL rmid_miss_cnt got=%0d exp=0", miss_cnt); else passed++;
      checks++; if (hit_cnt !== 32'h0) $display("FAIL rmid_hit_cnt got=%0d exp=0", hit_cnt); else passed++;
      m_clear();
      exp_hits = 0;
      exp_miss = 0;
      @(negedge clk);
      cpu_req    = 1'b0;
      rst        = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      fetch(a, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(a, 1'b0, 1'b0, -1);
      checks++; if (h !== 1'b0) $display("FAIL rmid_after_hit got=%b exp=0", h); else passed++;
      checks++; if (ins !== mem_word(a)) $display("FAIL rmid_after_ins got=%h exp=%h", ins, mem_word(a)); else passed++;
      repeat (3) begin
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      fetch(a, 0, -1, 1'b0, h, ins, rs, ra, rr);
      m_update(a, 1'b1, 1'b0, -1);
      checks++; if (h !== 1'b1) $display("FAIL stray_hit got=%b exp=1", h); else passed++;
      checks++; if (ins !== mem_word(a)) $display("FAIL stray_ins got=%h exp=%h", ins, mem_word(a)); else passed++;
      #1;
      checks++; if (miss_cnt !== exp_miss) $display("FAIL stray_miss_cnt got=%0d exp=%0d", miss_cnt, exp_miss); else passed++;
   endtask

   task automatic test_counter_wrap();
      bit h; logic [31:0] ins; logic rs; logic [ADDR_W-1:0] ra; logic rr;
      @(negedge clk);
      dut.r_miss_cnt = 32'hFFFF_FFFF;
      fetch(30'h3E10, 0, -1, 1'b0, h, ins, rs, ra, rr);
      checks++; if (h !== 1'b0) $display("FAIL wrap_hit got=%b exp=0", h); else passed++;
      #1;
      checks++; if (miss_cnt !== 32'h0) $display("FAIL wrap_miss_cnt got=%h exp=0", miss_cnt); else passed++;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit_after_fill();
      test_conflict();
      test_stall_inv();
      test_random();
      test_reset_mid_refill();
      test_counter_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
